cp_insert_mc: RTL and testbench

Parametrised multi-channel post-processor that sits at the IFFT/FFT core output. It is the generalised successor to the single-channel, fixed-size post-processor. In IFFT mode it buffers each symbol in a ping-pong RAM and replays it at the sample rate with a run-time cyclic prefix prepended. In FFT mode it passes data through. Compared with its predecessor, it adds arbitrary FFT length, run-time CP length, NCH parallel channels, bank overflow and length-error detection, a CP marker, and gapless back-to-back replay.

---
 rtl/cp_insert_mc.sv | 188 ++++++++++++++++++
 tb/tb_cp_insert_mc.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cp_insert_mc.sv
// cp_insert_mc: multi-channel IFFT post-processor; ping-pong symbol buffer replayed at the sample rate
// with a run-time cyclic prefix, or a one-cycle registered pass-through in FFT mode.
module cp_insert_mc #(
    parameter int DATA_NBIT    = 16,
    parameter int NCH          = 2,
    parameter int FFT_MAX_LOG2 = 11,
    parameter int CLK_FS_RATIO = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fft_type,
    input  logic [FFT_MAX_LOG2:0]      fft_len,
    input  logic [FFT_MAX_LOG2-1:0]    cp_len,
    input  logic                       din_sop,
    input  logic                       din_valid,
    input  logic [NCH*2*DATA_NBIT-1:0] din_data,
    input  logic                       din_eop,
    input  logic                       din_tag,
    output logic [NCH*2*DATA_NBIT-1:0] dout_data,
    output logic                       dout_valid,
    output logic                       dout_sop,
    output logic                       dout_tag,
    output logic                       dout_cp,
    output logic                       ovf_err,
    output logic                       len_err,
    output logic                       busy
);
    localparam int W  = NCH * 2 * DATA_NBIT;
    localparam int L  = FFT_MAX_LOG2 + 1;
    localparam int A  = FFT_MAX_LOG2;
    localparam int CW = $clog2(CLK_FS_RATIO);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_t;
    typedef enum logic [1:0] {S_IDLE, S_CP, S_SYM} rd_t;

    logic [W-1:0] mem [2**L];
    logic [W-1:0] rd_data_q;
    bank_t bank_q [2];
    bank_t bank_d [2];
    logic [1:0][L-1:0] len_q, len_d;
    logic [1:0][A-1:0] cp_q, cp_d;
    logic [1:0] tag_q, tag_d;
    logic wr_bank_q, wr_bank_d, wr_act_q, wr_act_d;
    logic [L-1:0] wr_off_q, wr_off_d, wcnt;
    rd_t rd_st_q, rd_st_d;
    logic rd_bank_q, rd_bank_d;
    logic [L-1:0] rd_off_q, rd_off_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic p1_valid_q, p1_valid_d, p1_sop_q, p1_sop_d, p1_tag_q, p1_tag_d, p1_cp_q, p1_cp_d;
    logic [W-1:0] dout_data_q, dout_data_d;
    logic dout_valid_q, dout_valid_d, dout_sop_q, dout_sop_d, dout_tag_q, dout_tag_d;
    logic dout_cp_q, dout_cp_d, ovf_err_q, ovf_err_d, len_err_q, len_err_d;
    logic we, strobe, first, start, sb;
    logic [A-1:0] wa;

    always_comb begin
        bank_d = bank_q;
        len_d = len_q;
        cp_d = cp_q;
        tag_d = tag_q;
        wr_bank_d = wr_bank_q;
        wr_act_d = wr_act_q;
        wr_off_d = wr_off_q;
        rd_st_d = rd_st_q;
        rd_bank_d = rd_bank_q;
        rd_off_d = rd_off_q;
        ovf_err_d = 1'b0;
        len_err_d = 1'b0;
        we = 1'b0;
        wa = wr_off_q[A-1:0];
        wcnt = wr_off_q + L'(1);
        strobe = rd_st_q != S_IDLE && cnt_q == '0;
        cnt_d = (rd_st_q == S_IDLE || cnt_q == CW'(CLK_FS_RATIO - 1)) ? '0 : cnt_q + CW'(1);
        first = (rd_st_q == S_CP && rd_off_q == len_q[rd_bank_q] - L'(cp_q[rd_bank_q])) ||
                (rd_st_q == S_SYM && rd_off_q == '0 && cp_q[rd_bank_q] == '0);
        start = rd_st_q == S_IDLE && bank_q[rd_bank_q] == B_FULL;
        sb = rd_bank_q;
        if (rd_st_q == S_CP && strobe) begin
            rd_st_d = (rd_off_q == len_q[rd_bank_q] - L'(1)) ? S_SYM : S_CP;
            rd_off_d = (rd_off_q == len_q[rd_bank_q] - L'(1)) ? '0 : rd_off_q + L'(1);
        end
        if (rd_st_q == S_SYM && strobe)
            rd_off_d = rd_off_q + L'(1);
        // A symbol is retired at the end of its last sample period so a queued one starts on cadence
        if (rd_st_q == S_SYM && cnt_q == CW'(CLK_FS_RATIO - 1) && rd_off_q == len_q[rd_bank_q]) begin
            bank_d[rd_bank_q] = B_EMPTY;
            rd_bank_d = ~rd_bank_q;
            rd_st_d = S_IDLE;
            sb = ~rd_bank_q;
            start = bank_q[sb] == B_FULL;
        end
        if (start) begin
            bank_d[sb] = B_READING;
            rd_st_d = (cp_q[sb] != '0) ? S_CP : S_SYM;
            rd_off_d = (cp_q[sb] != '0) ? len_q[sb] - L'(cp_q[sb]) : '0;
        end
        if (fft_type && din_valid) begin
            if (din_sop) begin
                if (bank_q[wr_bank_q] == B_EMPTY || bank_q[wr_bank_q] == B_FILLING) begin
                    we = 1'b1;
                    wa = '0;
                    wcnt = L'(1);
                    wr_act_d = 1'b1;
                    wr_off_d = L'(1);
                    bank_d[wr_bank_q] = B_FILLING;
                    len_d[wr_bank_q] = fft_len;
                    cp_d[wr_bank_q] = cp_len;
                    tag_d[wr_bank_q] = din_tag;
                end else begin
                    ovf_err_d = 1'b1;
                    wr_act_d = 1'b0;
                end
            end else if (wr_act_q) begin
                we = 1'b1;
                wr_off_d = wcnt;
            end
            if (din_eop && we) begin
                wr_act_d = 1'b0;
                if (wcnt == len_d[wr_bank_q]) begin
                    bank_d[wr_bank_q] = B_FULL;
                    wr_bank_d = ~wr_bank_q;
                end else begin
                    bank_d[wr_bank_q] = B_EMPTY;
                    len_err_d = 1'b1;
                end
            end
        end
        p1_valid_d = strobe;
        p1_sop_d = strobe && first;
        p1_tag_d = strobe && first && tag_q[rd_bank_q];
        p1_cp_d = strobe && rd_st_q == S_CP;
        dout_valid_d = fft_type ? p1_valid_q : din_valid;
        dout_data_d = fft_type ? (p1_valid_q ? rd_data_q : dout_data_q) : din_data;
        dout_sop_d = fft_type ? p1_sop_q : din_sop & din_valid;
        dout_tag_d = fft_type ? p1_tag_q : din_tag & din_sop & din_valid;
        dout_cp_d = fft_type & p1_cp_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_q <= '{B_EMPTY, B_EMPTY};
            len_q <= '0;
            cp_q <= '0;
            tag_q <= '0;
            wr_bank_q <= 1'b0;
            wr_act_q <= 1'b0;
            wr_off_q <= '0;
            rd_st_q <= S_IDLE;
            rd_bank_q <= 1'b0;
            rd_off_q <= '0;
            cnt_q <= '0;
            {p1_valid_q, p1_sop_q, p1_tag_q, p1_cp_q} <= '0;
            dout_data_q <= '0;
            {dout_valid_q, dout_sop_q, dout_tag_q, dout_cp_q, ovf_err_q, len_err_q} <= '0;
        end else begin
            bank_q <= bank_d;
            len_q <= len_d;
            cp_q <= cp_d;
            tag_q <= tag_d;
            wr_bank_q <= wr_bank_d;
            wr_act_q <= wr_act_d;
            wr_off_q <= wr_off_d;
            rd_st_q <= rd_st_d;
            rd_bank_q <= rd_bank_d;
            rd_off_q <= rd_off_d;
            cnt_q <= cnt_d;
            {p1_valid_q, p1_sop_q, p1_tag_q, p1_cp_q} <= {p1_valid_d, p1_sop_d, p1_tag_d, p1_cp_d};
            dout_data_q <= dout_data_d;
            {dout_valid_q, dout_sop_q, dout_tag_q, dout_cp_q, ovf_err_q, len_err_q} <=
                {dout_valid_d, dout_sop_d, dout_tag_d, dout_cp_d, ovf_err_d, len_err_d};
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[{wr_bank_q, wa}] <= din_data;
        rd_data_q <= mem[{rd_bank_q, rd_off_q[A-1:0]}];
    end

    assign dout_data = dout_data_q;
    assign dout_valid = dout_valid_q;
    assign dout_sop = dout_sop_q;
    assign dout_tag = dout_tag_q;
    assign dout_cp = dout_cp_q;
    assign ovf_err = ovf_err_q;
    assign len_err = len_err_q;
    assign busy = bank_q[0] != B_EMPTY || bank_q[1] != B_EMPTY || rd_st_q != S_IDLE;
endmodule

// File: tb/tb_cp_insert_mc.sv
// tb_cp_insert_mc: directed stimulus with a scoreboard queue; a monitor pops an expected
// sample (data, flags, arrival cycle) for every dout_valid.
module tb_cp_insert_mc;
    typedef struct {
        logic [63:0] d;
        logic [2:0]  f;
        int          at;
    } exp_t;

    logic        clk, reset, fft_type;
    logic [11:0] fft_len;
    logic [10:0] cp_len;
    logic        din_sop, din_valid, din_eop, din_tag;
    logic [63:0] din_data, dout_data;
    logic        dout_valid, dout_sop, dout_tag, dout_cp, ovf_err, len_err, busy;

    int   checks = 0, failures = 0, cyc = 0, ovf_n = 0, len_n = 0;
    exp_t exp_q[$];
    exp_t me;

    cp_insert_mc #(.DATA_NBIT(16), .NCH(2), .FFT_MAX_LOG2(11), .CLK_FS_RATIO(5)) dut (
        .clk(clk), .reset(reset), .fft_type(fft_type), .fft_len(fft_len), .cp_len(cp_len),
        .din_sop(din_sop), .din_valid(din_valid), .din_data(din_data), .din_eop(din_eop),
        .din_tag(din_tag), .dout_data(dout_data), .dout_valid(dout_valid), .dout_sop(dout_sop),
        .dout_tag(dout_tag), .dout_cp(dout_cp), .ovf_err(ovf_err), .len_err(len_err), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mk(input int sym, input int off);
        return {16'(off + 'h1000), 16'(sym * 3 + 1), 16'(off), 16'(sym)};
    endfunction

    task automatic push_sym(input int sym, input int len, input int cp, input bit tag, input int base);
        exp_t e;
        for (int i = 0; i < cp + len; i++) begin
            e.d = mk(sym, (i < cp) ? len - cp + i : i - cp);
            e.f = {i == 0, tag && i == 0, i < cp};
            e.at = base + 5 * i;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_sym(input int sym, input int n, input int len, input int cp, input bit tag,
                            input bit exp_ovf, output int eop_cyc);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) chk("len_err_idle", 64'(len_err), 64'(0));
            if (i == 1) chk("ovf_err", 64'(ovf_err), 64'(exp_ovf));
            din_valid = 1'b1;
            din_sop = i == 0;
            din_eop = i == n - 1;
            din_tag = (i == 0) ? tag : ~tag;
            fft_len = 12'(len);
            cp_len = 11'(cp);
            din_data = mk(sym, i);
            eop_cyc = cyc;
        end
    endtask

    task automatic finish_in(input bit exp_len);
        @(negedge clk);
        chk("len_err", 64'(len_err), 64'(exp_len));
        din_valid = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
        din_tag = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_data"}, dout_data, 64'(0));
        chk({nm, "_flags"}, 64'({dout_valid, dout_sop, dout_tag, dout_cp, ovf_err, len_err, busy}), 64'(0));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (ovf_err) ovf_n++;
            if (len_err) len_n++;
            if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: dout_valid=1 data=%0h at cycle %0d, required no output", dout_data, cyc);
                end else begin
                    me = exp_q.pop_front();
                    chk("dout_data", dout_data, me.d);
                    chk("sop_tag_cp", 64'({dout_sop, dout_tag, dout_cp}), 64'(me.f));
                    chk("out_cycle", 64'(cyc), 64'(me.at));
                end
            end else begin
                chk("idle_flags", 64'({dout_sop, dout_tag, dout_cp}), 64'(0));
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached with %0d samples pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int e1, e2, o0, l0, seen;
        bit v, fs;
        reset = 1'b1;
        fft_type = 1'b1;
        fft_len = '0;
        cp_len = '0;
        din_sop = 1'b0;
        din_valid = 1'b0;
        din_eop = 1'b0;
        din_tag = 1'b0;
        din_data = '0;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset_hold");
        #2 reset = 1'b0;
        @(negedge clk);
        chk_reset_outs("after_reset");

        // single symbol, len 128, cp 9, I of ch0 carries the offset
        send_sym(1, 128, 128, 9, 1'b1, 1'b0, e1);
        finish_in(1'b0);
        push_sym(1, 128, 9, 1'b1, e1 + 4);
        wait_drain(1000);
        repeat (8) @(negedge clk);
        chk("busy_after_t1", 64'(busy), 64'(0));

        // two back-to-back 1536-sample symbols, replayed gaplessly
        send_sym(2, 1536, 1536, 144, 1'b0, 1'b0, e1);
        push_sym(2, 1536, 144, 1'b0, e1 + 4);
        send_sym(3, 1536, 1536, 160, 1'b1, 1'b0, e2);
        finish_in(1'b0);
        push_sym(3, 1536, 160, 1'b1, e1 + 4 + 5 * 1680);
        wait_drain(20000);
        repeat (8) @(negedge clk);
        chk("busy_after_t2", 64'(busy), 64'(0));

        // three symbols at full rate: the third finds no free bank
        o0 = ovf_n;
        l0 = len_n;
        send_sym(4, 128, 128, 9, 1'b1, 1'b0, e1);
        push_sym(4, 128, 9, 1'b1, e1 + 4);
        send_sym(5, 128, 128, 9, 1'b0, 1'b0, e2);
        push_sym(5, 128, 9, 1'b0, e1 + 4 + 5 * 137);
        send_sym(6, 128, 128, 9, 1'b1, 1'b1, e2);
        finish_in(1'b0);
        wait_drain(2000);
        repeat (8) @(negedge clk);
        chk("ovf_count_t3", 64'(ovf_n - o0), 64'(1));
        chk("len_count_t3", 64'(len_n - l0), 64'(0));
        chk("busy_after_t3", 64'(busy), 64'(0));

        // short symbol: length error, nothing replayed
        l0 = len_n;
        send_sym(7, 100, 128, 9, 1'b0, 1'b0, e1);
        finish_in(1'b1);
        @(negedge clk);
        chk("len_err_pulse_end", 64'(len_err), 64'(0));
        repeat (3) @(negedge clk);
        chk("busy_after_len_err", 64'(busy), 64'(0));
        repeat (40) @(negedge clk);
        chk("len_count_t4", 64'(len_n - l0), 64'(1));

        // pass-through: dout is din one cycle later
        o0 = ovf_n;
        l0 = len_n;
        fft_type = 1'b0;
        fs = 1'b1;
        for (int k = 0; k < 300;) begin
            @(negedge clk);
            v = $urandom_range(0, 3) != 0;
            din_valid = v;
            din_sop = v && fs;
            din_tag = 1'b1;
            din_eop = v && k == 299;
            din_data = {$urandom, $urandom};
            if (v) begin
                me.d = din_data;
                me.f = {fs, fs, 1'b0};
                me.at = cyc + 1;
                exp_q.push_back(me);
                fs = 1'b0;
                k++;
            end
        end
        finish_in(1'b0);
        wait_drain(20);
        chk("ovf_count_t5", 64'(ovf_n - o0), 64'(0));
        chk("len_count_t5", 64'(len_n - l0), 64'(0));
        fft_type = 1'b1;

        // reset in the middle of the cyclic prefix, then a fresh symbol
        send_sym(8, 128, 128, 9, 1'b1, 1'b0, e1);
        finish_in(1'b0);
        push_sym(8, 128, 9, 1'b1, e1 + 4);
        seen = 0;
        for (int n = 0; n < 3000 && seen < 3; n++) begin
            @(negedge clk);
            if (dout_valid) seen++;
        end
        chk("mid_cp_reached", 64'(seen), 64'(3));
        #2 reset = 1'b1;
        #1 chk_reset_outs("reset_mid_cp");
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        repeat (60) @(negedge clk);
        chk("busy_after_reset", 64'(busy), 64'(0));
        send_sym(9, 16, 16, 4, 1'b0, 1'b0, e1);
        finish_in(1'b0);
        push_sym(9, 16, 4, 1'b0, e1 + 4);
        wait_drain(300);
        repeat (8) @(negedge clk);
        chk("busy_end", 64'(busy), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
